// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, instruction classes,
// FSM states, ALU-op / immediate / writeback-source / next-PC constants.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } instr_class_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_TRAP
    } state_t;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [4:0] BR_SEQ  = 5'b00000;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [4:0] BR_JUMP = 5'b10000;

    function automatic logic is_shift_f3(input logic [2:0] f3);
        return f3 == 3'b101;
    endfunction

endpackage

// File: rtl/rv_instr_classify.sv
// Combinational RV32I decode: opcode/f3/f7 -> instruction class and the static datapath selects.
// Unrecognised encodings map to CLS_ILLEGAL with every select at 0.
module rv_instr_classify
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   f3,
    input  logic [6:0]   f7,
    output instr_class_t cls,
    output logic [2:0]   imm_src,
    output logic         alua_src,
    output logic         alub_src,
    output logic [3:0]   alu_op
);

    always_comb begin
        cls      = CLS_ILLEGAL;
        imm_src  = 3'b000;
        alua_src = 1'b0;
        alub_src = 1'b0;
        alu_op   = ALU_ADD;
        case (opcode)
            OP_R: begin
                // f7=0100000 is only defined for SUB and SRA
                if (f7 == F7_ZERO || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
                    cls    = CLS_R;
                    alu_op = {f7[5], f3};
                end
            end
            OP_I: begin
                if ((f3 == 3'b001 && f7 == F7_ZERO) ||
                    (is_shift_f3(f3) && (f7 == F7_ZERO || f7 == F7_ALT)) ||
                    (f3 != 3'b001 && !is_shift_f3(f3))) begin
                    cls      = CLS_I;
                    imm_src  = IMM_I;
                    alub_src = 1'b1;
                    alu_op   = is_shift_f3(f3) ? {f7[5], f3} : {1'b0, f3};
                end
            end
            OP_LOAD: begin
                if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                    cls      = CLS_LOAD;
                    imm_src  = IMM_I;
                    alub_src = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
                    cls      = CLS_STORE;
                    imm_src  = IMM_S;
                    alub_src = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (f3 != 3'b010 && f3 != 3'b011) begin
                    cls     = CLS_BRANCH;
                    imm_src = IMM_B;
                end
            end
            OP_JAL: begin
                cls      = CLS_JAL;
                imm_src  = IMM_J;
                alua_src = 1'b1;
                alub_src = 1'b1;
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    cls      = CLS_JALR;
                    imm_src  = IMM_I;
                    alub_src = 1'b1;
                end
            end
            OP_LUI: begin
                cls      = CLS_LUI;
                imm_src  = IMM_U;
                alub_src = 1'b1;
                alu_op   = ALU_PASS_B;
            end
            OP_AUIPC: begin
                cls      = CLS_AUIPC;
                imm_src  = IMM_U;
                alua_src = 1'b1;
                alub_src = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK, 3-5 cycles plus one per ack wait,
// holding on imem/dmem acks and counting retirements. ILLEGAL_TRAP_EN makes illegal encodings trap.
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int RET_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           f3,
    input  logic [6:0]           f7,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 ir_wr,
    output logic                 pc_wr,
    output logic [2:0]           imm_src,
    output logic                 alua_src,
    output logic                 alub_src,
    output logic [3:0]           alu_op,
    output logic                 dm_wr,
    output logic [2:0]           dm_ctrl,
    output logic [1:0]           ru_data_wr_src,
    output logic                 ru_wr,
    output logic [4:0]           br_op,
    output logic [RET_CNT_W-1:0] instret,
    output logic                 illegal_instr
);

    state_t                r_state;
    state_t                w_next;
    instr_class_t          r_class;
    logic [RET_CNT_W-1:0]  r_instret;

    instr_class_t          w_cls;
    logic [2:0]            w_imm_src;
    logic                  w_alua_src;
    logic                  w_alub_src;
    logic [3:0]            w_alu_op;

    logic                  w_sel_en;
    logic                  w_imem_req;
    logic                  w_dmem_req;
    logic                  w_ir_wr;
    logic                  w_pc_wr;
    logic                  w_dm_wr;
    logic [2:0]            w_dm_ctrl;
    logic [1:0]            w_ru_src;
    logic                  w_ru_wr;
    logic [4:0]            w_br_op;
`ifdef ILLEGAL_TRAP_EN
    logic                  w_illegal;
`endif

    rv_instr_classify u_classify (
        .opcode   (opcode),
        .f3       (f3),
        .f7       (f7),
        .cls      (w_cls),
        .imm_src  (w_imm_src),
        .alua_src (w_alua_src),
        .alub_src (w_alub_src),
        .alu_op   (w_alu_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_class <= CLS_ILLEGAL;
        end else if (r_state == ST_DECODE) begin
            r_class <= w_cls;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_pc_wr) begin
            r_instret <= r_instret + RET_CNT_W'(1);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_sel_en   = 1'b0;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_ir_wr    = 1'b0;
        w_pc_wr    = 1'b0;
        w_dm_wr    = 1'b0;
        w_dm_ctrl  = 3'b000;
        w_ru_src   = WB_ALU;
        w_ru_wr    = 1'b0;
        w_br_op    = BR_SEQ;
`ifdef ILLEGAL_TRAP_EN
        w_illegal  = 1'b0;
`endif
        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_ir_wr = 1'b1;
                    w_next  = ST_DECODE;
                end
            end
            ST_DECODE: w_next = ST_EXECUTE;
            ST_EXECUTE: begin
                w_sel_en = 1'b1;
                case (r_class)
                    CLS_BRANCH: begin
                        w_br_op = {BR_COND, f3};
                        w_pc_wr = 1'b1;
                        w_next  = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: w_next = ST_MEM;
                    CLS_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                        w_next  = ST_TRAP;
`else
                        w_pc_wr = 1'b1;
                        w_next  = ST_FETCH;
`endif
                    end
                    default: w_next = ST_WRITEBACK;
                endcase
            end
            ST_MEM: begin
                w_sel_en   = 1'b1;
                w_dmem_req = 1'b1;
                w_dm_ctrl  = f3;
                w_dm_wr    = (r_class == CLS_STORE);
                if (dmem_ack) begin
                    // a store retires on acceptance; a load still needs its writeback
                    if (r_class == CLS_STORE) begin
                        w_pc_wr = 1'b1;
                        w_next  = ST_FETCH;
                    end else begin
                        w_next  = ST_WRITEBACK;
                    end
                end
            end
            ST_WRITEBACK: begin
                w_sel_en = 1'b1;
                w_ru_wr  = 1'b1;
                w_pc_wr  = 1'b1;
                w_next   = ST_FETCH;
                case (r_class)
                    CLS_LOAD: w_ru_src = WB_MEM;
                    CLS_JAL, CLS_JALR: begin
                        w_ru_src = WB_PC4;
                        w_br_op  = BR_JUMP;
                    end
                    default: w_ru_src = WB_ALU;
                endcase
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: w_illegal = 1'b1;
`endif
            default: w_next = ST_FETCH;
        endcase

        // outputs collapse asynchronously while reset is held
        if (rst) begin
            w_sel_en   = 1'b0;
            w_imem_req = 1'b0;
            w_dmem_req = 1'b0;
            w_ir_wr    = 1'b0;
            w_pc_wr    = 1'b0;
            w_dm_wr    = 1'b0;
            w_dm_ctrl  = 3'b000;
            w_ru_src   = WB_ALU;
            w_ru_wr    = 1'b0;
            w_br_op    = BR_SEQ;
`ifdef ILLEGAL_TRAP_EN
            w_illegal  = 1'b0;
`endif
        end
    end

    assign imem_req       = w_imem_req;
    assign dmem_req       = w_dmem_req;
    assign ir_wr          = w_ir_wr;
    assign pc_wr          = w_pc_wr;
    assign dm_wr          = w_dm_wr;
    assign dm_ctrl        = w_dm_ctrl;
    assign ru_data_wr_src = w_ru_src;
    assign ru_wr          = w_ru_wr;
    assign br_op          = w_br_op;
    assign imm_src        = w_sel_en ? w_imm_src  : 3'b000;
    assign alua_src       = w_sel_en ? w_alua_src : 1'b0;
    assign alub_src       = w_sel_en ? w_alub_src : 1'b0;
    assign alu_op         = w_sel_en ? w_alu_op   : 4'b0000;
    assign instret        = r_instret;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr  = w_illegal;
`else
    assign illegal_instr  = 1'b0;
`endif

endmodule
